// File: rtl/signed_div_pow2_pkg.sv
// -----------------------------------------------------------------------------
// signed_div_pow2_pkg
// Shared types for the serial signed divide-by-2^S unit.
//   state_t : handshake/shift FSM states
//   mode_e  : rounding mode (floor = arithmetic shift, trunc = round toward zero)
// Optional feature macro used by the top: SIGNED_DIV_POW2_SERIAL_REMAINDER_EN
// -----------------------------------------------------------------------------
package signed_div_pow2_pkg;

   typedef enum logic [1:0] {
      ST_IDLE  = 2'd0,
      ST_SHIFT = 2'd1,
      ST_DONE  = 2'd2
   } state_t;

   typedef enum logic {
      MODE_FLOOR = 1'b0,
      MODE_TRUNC = 1'b1
   } mode_e;

   // Bits needed to encode a per-cycle shift amount in 0..step.
   function automatic int step_width(input int step);
      return (step < 1) ? 1 : $clog2(step + 1);
   endfunction

endpackage

// File: rtl/signed_div_pow2_serial_arith_shift_step.sv
// -----------------------------------------------------------------------------
// arith_shift_step
// Combinational arithmetic right shift by k in 0..STEP, plus the OR of every
// bit shifted out (sticky). Each candidate shift is wired bit by bit from
// constant indices, then one candidate is selected by k, so no variable shifter
// is built.
// Ports:
//   din    in  N                 value to shift (two's complement)
//   k      in  step_width(STEP)  shift amount, 0..STEP
//   dout   out N                 din shifted right by k, sign-filled
//   sticky out 1                 OR of the k bits shifted out
// -----------------------------------------------------------------------------
module arith_shift_step
   import signed_div_pow2_pkg::*;
#(
   parameter int N    = 8,
   parameter int STEP = 1
) (
   input  logic [N-1:0]                din,
   input  logic [step_width(STEP)-1:0] k,
   output logic [N-1:0]                dout,
   output logic                        sticky
);

   localparam int KW = step_width(STEP);

   logic [STEP:0][N-1:0] cand;
   logic [STEP:0]        cand_sticky;

   for (genvar j = 0; j <= STEP; j++) begin : g_amt
      for (genvar i = 0; i < N; i++) begin : g_bit
         // Positions beyond the MSB are filled with the sign bit.
         localparam int SRC = (i + j < N) ? (i + j) : (N - 1);
         assign cand[j][i] = din[SRC];
      end
      if (j == 0) begin : g_none
         assign cand_sticky[j] = 1'b0;
      end else begin : g_some
         assign cand_sticky[j] = |din[j-1:0];
      end
   end

   // NOTE: every output of a combinational block gets a default first so no
   // path leaves it unassigned, which would otherwise infer a latch.
   always_comb begin
      dout   = cand[0];
      sticky = 1'b0;
      for (int j = 1; j <= STEP; j++) begin
         if (k == KW'(j)) begin
            dout   = cand[j];
            sticky = cand_sticky[j];
         end
      end
   end

endmodule

// File: rtl/signed_div_pow2_serial.sv
// -----------------------------------------------------------------------------
// signed_div_pow2_serial
// Multi-cycle signed divide by 2^S with runtime S, shifting at most STEP bits
// per cycle. MODE_FLOOR matches >>>, MODE_TRUNC rounds toward zero.
// The first shift step is taken on the accept edge itself, so down_valid rises
// ceil(S/STEP) cycles after the accept cycle (one cycle when S = 0).
// Ports:
//   clk        in  1          clock
//   rst_n      in  1          synchronous active-low reset
//   up_valid   in  1          operand valid
//   up_ready   out 1          unit idle, operand accepted when up_valid
//   up_data    in  N          signed dividend
//   up_shamt   in  $clog2(N)  shift amount S, 0..N-1
//   up_mode    in  1          0 = MODE_FLOOR, 1 = MODE_TRUNC
//   down_valid out 1          result valid, held until down_ready
//   down_ready in  1          consumer accepts result
//   down_data  out N          signed quotient
//   down_rem   out N          signed remainder up_data - down_data*2^S
//                             (only with SIGNED_DIV_POW2_SERIAL_REMAINDER_EN)
// -----------------------------------------------------------------------------
module signed_div_pow2_serial
   import signed_div_pow2_pkg::*;
#(
   parameter int N    = 8,
   parameter int STEP = 1
) (
   input  logic                 clk,
   input  logic                 rst_n,
   input  logic                 up_valid,
   output logic                 up_ready,
   input  logic [N-1:0]         up_data,
   input  logic [$clog2(N)-1:0] up_shamt,
   input  logic                 up_mode,
   output logic                 down_valid,
   input  logic                 down_ready,
   output logic [N-1:0]         down_data
`ifdef SIGNED_DIV_POW2_SERIAL_REMAINDER_EN
   ,
   output logic [N-1:0]         down_rem
`endif
);

   localparam int SW = $clog2(N);
   localparam int KW = step_width(STEP);

   state_t        state;
   logic [N-1:0]  data_q;
   mode_e         mode_q;
   logic [SW-1:0] remain_q;
   logic          sticky_q;

   // Operand seen by the shift step: the incoming one while idle, the
   // partially shifted one afterwards.
   logic [N-1:0]  cur_data;
   logic [SW-1:0] cur_remain;
   mode_e         cur_mode;
   logic          cur_sticky;

   logic [KW-1:0] k;
   logic [N-1:0]  step_data;
   logic          step_sticky;
   logic          advance;
   logic          last_step;
   logic          sticky_all;
   logic          adj;
   logic [N-1:0]  result;

   always_comb begin
      cur_data   = data_q;
      cur_remain = remain_q;
      cur_mode   = mode_q;
      cur_sticky = sticky_q;
      if (state == ST_IDLE) begin
         cur_data   = up_data;
         cur_remain = up_shamt;
         cur_mode   = mode_e'(up_mode);
         cur_sticky = 1'b0;
      end
   end

   always_comb begin
      k = (int'(cur_remain) > STEP) ? KW'(STEP) : KW'(cur_remain);
   end

   arith_shift_step #(
      .N    (N),
      .STEP (STEP)
   ) u_step (
      .din    (cur_data),
      .k      (k),
      .dout   (step_data),
      .sticky (step_sticky)
   );

   assign advance    = (state == ST_SHIFT) || ((state == ST_IDLE) && up_valid);
   assign last_step  = (cur_remain == SW'(k));
   assign sticky_all = cur_sticky | step_sticky;

   // Truncation differs from floor only for a negative dividend that lost
   // non-zero bits; the floored quotient is then <= -1, so +1 cannot overflow.
   assign adj    = last_step && (cur_mode == MODE_TRUNC) && step_data[N-1] && sticky_all;
   assign result = step_data + {{(N-1){1'b0}}, adj};

   // NOTE: sequential state uses non-blocking assignments so every register
   // samples pre-edge values regardless of statement order.
   always_ff @(posedge clk) begin
      if (!rst_n) begin
         state    <= ST_IDLE;
         data_q   <= '0;
         mode_q   <= MODE_FLOOR;
         remain_q <= '0;
         sticky_q <= 1'b0;
      end else begin
         case (state)
            ST_IDLE, ST_SHIFT: begin
               if (advance) begin
                  data_q   <= result;
                  mode_q   <= cur_mode;
                  remain_q <= cur_remain - SW'(k);
                  sticky_q <= sticky_all;
                  state    <= last_step ? ST_DONE : ST_SHIFT;
               end
            end
            ST_DONE: begin
               if (down_ready) begin
                  state <= ST_IDLE;
               end
            end
            default: state <= ST_IDLE;
         endcase
      end
   end

   assign up_ready   = (state == ST_IDLE);
   assign down_valid = (state == ST_DONE);
   assign down_data  = data_q;

`ifdef SIGNED_DIV_POW2_SERIAL_REMAINDER_EN
   // Remainder: shifted-out bits are stacked at their original positions,
   // giving the non-negative floor remainder; the truncation adjust then
   // subtracts 2^S so its sign follows the dividend.
   logic [N-1:0]  rem_q;
   logic [SW-1:0] shamt_q;
   logic [SW-1:0] cur_shamt;
   logic [SW-1:0] done_cnt;
   logic [N-1:0]  cur_rem_acc;
   logic [N-1:0]  out_bits;
   logic [N-1:0]  rem_next;

   always_comb begin
      cur_shamt   = shamt_q;
      cur_rem_acc = rem_q;
      if (state == ST_IDLE) begin
         cur_shamt   = up_shamt;
         cur_rem_acc = '0;
      end
      done_cnt = cur_shamt - cur_remain;
      out_bits = cur_data & ((N'(1) << k) - N'(1));
      rem_next = cur_rem_acc | (out_bits << done_cnt);
      if (adj) begin
         rem_next = rem_next - (N'(1) << cur_shamt);
      end
   end

   always_ff @(posedge clk) begin
      if (!rst_n) begin
         rem_q   <= '0;
         shamt_q <= '0;
      end else if (advance) begin
         rem_q   <= rem_next;
         shamt_q <= cur_shamt;
      end
   end

   assign down_rem = rem_q;
`endif

endmodule
